// File: rtl/conv_window_engine.sv
// Sliding-window 2-D convolution core: kernel-load FSM, window fill tracking and a
// 3-stage product/adder-tree/output pipeline. Optional build macro: CONV_SAT_EN.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_KLOAD | collecting kernel columns; image columns are ignored
// S_FILL  | kernel ready, filling the window with image columns
// S_RUN   | window full, every image column issues a result token
module conv_window_engine #(
    parameter int BIT_LEN   = 8,
    parameter int M_LEN     = 3,
    parameter int CONV_LEN  = 20,
    parameter int CONV_LPOS = 13,
    parameter int OUT_SHIFT = CONV_LEN - CONV_LPOS
) (
    input  logic                       CLK100MHZ,
    input  logic                       i_reset_n,
    input  logic [M_LEN*BIT_LEN-1:0]   i_dato,
    input  logic                       i_selecK_I,
    input  logic                       i_valid,
    input  logic                       i_sof,
    output logic [CONV_LPOS-1:0]       o_data,
    output logic                       o_valid,
    output logic                       o_kernel_ready
);

    localparam int COL_W  = M_LEN * BIT_LEN;
    localparam int PROD_W = 2 * BIT_LEN;
    localparam int N_PROD = M_LEN * M_LEN;
    localparam int CNT_W  = $clog2(M_LEN + 1);
    localparam int HI_LSB = OUT_SHIFT + CONV_LPOS - 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(M_LEN - 1);

    typedef enum logic [1:0] {S_KLOAD, S_FILL, S_RUN} state_t;

    state_t                     state;
    logic [CNT_W-1:0]           kcnt;
    logic [CNT_W-1:0]           icnt;
    logic [COL_W-1:0]           kernel [M_LEN];
    logic [COL_W-1:0]           window [M_LEN];
    logic                       tok;
    logic signed [PROD_W-1:0]   prod [N_PROD];
    logic                       v1;
    logic                       v2;
    logic signed [CONV_LEN-1:0] sum_c;
    logic signed [CONV_LEN-1:0] sum_r;
    logic [CONV_LPOS-1:0]       s;
    logic                       kernel_col;
    logic                       image_col;
    logic                       sum_unused;

    assign kernel_col = i_valid & ~i_selecK_I;
    assign image_col  = i_valid & i_selecK_I;
    assign sum_unused = ^sum_r;

    always_ff @(posedge CLK100MHZ or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state          <= S_KLOAD;
            kcnt           <= '0;
            icnt           <= '0;
            tok            <= 1'b0;
            o_kernel_ready <= 1'b0;
            for (int k = 0; k < M_LEN; k++) begin
                kernel[k] <= '0;
                window[k] <= '0;
            end
        end else begin
            tok <= 1'b0;
            case (state)
                S_KLOAD: begin
                    if (kernel_col) begin
                        for (int k = 0; k < M_LEN - 1; k++) kernel[k] <= kernel[k+1];
                        kernel[M_LEN-1] <= i_dato;
                        kcnt <= kcnt + 1'b1;
                        if (kcnt == LAST_CNT) begin
                            state          <= S_FILL;
                            o_kernel_ready <= 1'b1;
                            icnt           <= '0;
                        end
                    end
                end
                default: begin
                    if (kernel_col) begin
                        // Tokens already in flight keep the products they registered.
                        for (int k = 0; k < M_LEN - 1; k++) kernel[k] <= kernel[k+1];
                        kernel[M_LEN-1] <= i_dato;
                        kcnt           <= CNT_W'(1);
                        icnt           <= '0;
                        state          <= S_KLOAD;
                        o_kernel_ready <= 1'b0;
                    end else if (image_col) begin
                        for (int k = 0; k < M_LEN - 1; k++) window[k] <= window[k+1];
                        window[M_LEN-1] <= i_dato;
                        if (i_sof) begin
                            icnt  <= CNT_W'(1);
                            state <= S_FILL;
                        end else if (state == S_RUN) begin
                            tok <= 1'b1;
                        end else begin
                            icnt <= icnt + 1'b1;
                            if (icnt == LAST_CNT) begin
                                state <= S_RUN;
                                tok   <= 1'b1;
                            end
                        end
                    end
                end
            endcase
        end
    end

    always_comb begin
        sum_c = '0;
        for (int i = 0; i < N_PROD; i++)
            sum_c = sum_c + {{(CONV_LEN-PROD_W){prod[i][PROD_W-1]}}, prod[i]};
    end

`ifdef CONV_SAT_EN
    logic [CONV_LEN-1-HI_LSB:0] hi_bits;
    assign hi_bits = sum_r[CONV_LEN-1:HI_LSB];

    always_comb begin
        s = sum_r[OUT_SHIFT +: CONV_LPOS];
        if (!((&hi_bits) || (~|hi_bits)))
            s = sum_r[CONV_LEN-1] ? {1'b1, {(CONV_LPOS-1){1'b0}}}
                                  : {1'b0, {(CONV_LPOS-1){1'b1}}};
    end
`else
    always_comb begin
        s = sum_r[OUT_SHIFT +: CONV_LPOS];
    end
`endif

    always_ff @(posedge CLK100MHZ or negedge i_reset_n) begin
        if (!i_reset_n) begin
            for (int i = 0; i < N_PROD; i++) prod[i] <= '0;
            v1      <= 1'b0;
            v2      <= 1'b0;
            sum_r   <= '0;
            o_valid <= 1'b0;
            o_data  <= {1'b1, {(CONV_LPOS-1){1'b0}}};
        end else begin
            v1      <= tok;
            v2      <= v1;
            o_valid <= v2;
            if (tok) begin
                for (int c = 0; c < M_LEN; c++)
                    for (int r = 0; r < M_LEN; r++)
                        prod[c*M_LEN+r] <= $signed(kernel[c][r*BIT_LEN +: BIT_LEN])
                                         * $signed(window[c][r*BIT_LEN +: BIT_LEN]);
            end
            if (v1) sum_r <= sum_c;
            // Offset-binary output: invert the sign bit of the sliced sample.
            if (v2) o_data <= {~s[CONV_LPOS-1], s[CONV_LPOS-2:0]};
        end
    end

endmodule

// File: tb/tb_conv_window_engine.sv
// Directed bench for conv_window_engine: default instance plus an OUT_SHIFT=4 instance
// sharing the same stimulus (exercises wrap or CONV_SAT_EN clamping).
module tb_conv_window_engine;

    logic        CLK100MHZ;
    logic        i_reset_n;
    logic [23:0] i_dato;
    logic        i_selecK_I;
    logic        i_valid;
    logic        i_sof;
    logic [12:0] o_data;
    logic        o_valid;
    logic        o_kernel_ready;
    logic [12:0] o_data2;
    logic        o_valid2;
    logic        o_kernel_ready2;

    int n_cmp = 0;
    int n_err = 0;

    localparam logic [23:0] K_ZERO = 24'h000000;
    localparam logic [23:0] K_CTR  = 24'h004000;
    localparam logic [23:0] K_NEG1 = 24'hFFFFFF;
    localparam logic [23:0] C_10   = 24'h0A0A0A;
    localparam logic [23:0] C_127  = 24'h7F7F7F;

`ifdef CONV_SAT_EN
    localparam logic [12:0] SAT_EXP2 = 13'h1FFF;
`else
    localparam logic [12:0] SAT_EXP2 = 13'h1370;
`endif

    conv_window_engine dut (
        .CLK100MHZ      (CLK100MHZ),
        .i_reset_n      (i_reset_n),
        .i_dato         (i_dato),
        .i_selecK_I     (i_selecK_I),
        .i_valid        (i_valid),
        .i_sof          (i_sof),
        .o_data         (o_data),
        .o_valid        (o_valid),
        .o_kernel_ready (o_kernel_ready)
    );

    conv_window_engine #(.OUT_SHIFT(4)) dut2 (
        .CLK100MHZ      (CLK100MHZ),
        .i_reset_n      (i_reset_n),
        .i_dato         (i_dato),
        .i_selecK_I     (i_selecK_I),
        .i_valid        (i_valid),
        .i_sof          (i_sof),
        .o_data         (o_data2),
        .o_valid        (o_valid2),
        .o_kernel_ready (o_kernel_ready2)
    );

    initial begin
        CLK100MHZ = 1'b0;
        forever #5 CLK100MHZ = ~CLK100MHZ;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic col(input logic sel, input logic sof, input logic [23:0] d);
        i_valid    = 1'b1;
        i_selecK_I = sel;
        i_sof      = sof;
        i_dato     = d;
        @(posedge CLK100MHZ);
        #1;
        i_valid = 1'b0;
        i_sof   = 1'b0;
    endtask

    task automatic ker(input logic [23:0] d);
        col(1'b0, 1'b0, d);
    endtask

    task automatic img(input logic [23:0] d);
        col(1'b1, 1'b0, d);
    endtask

    task automatic idle();
        i_valid = 1'b0;
        @(posedge CLK100MHZ);
        #1;
    endtask

    initial begin
        i_reset_n  = 1'b1;
        i_dato     = '0;
        i_selecK_I = 1'b0;
        i_valid    = 1'b0;
        i_sof      = 1'b0;

        // Reset without any clock edge
        #1 i_reset_n = 1'b0;
        #2;
        check("rst_data",  o_data, 13'h1000);
        check("rst_valid", o_valid, 1'b0);
        check("rst_kready", o_kernel_ready, 1'b0);
        check("rst_data2", o_data2, 13'h1000);
        #1 i_reset_n = 1'b1;

        // Identity kernel, pixels 10: sum 640 -> 13'h1005
        ker(K_ZERO);
        ker(K_CTR);
        check("kready_before_last", o_kernel_ready, 1'b0);
        ker(K_ZERO);
        check("kready_after_last", o_kernel_ready, 1'b1);
        img(C_10);
        img(C_10);
        img(C_10);
        check("id_valid_e0", o_valid, 1'b0);
        img(C_10);
        img(C_10);
        check("id_valid_e2", o_valid, 1'b0);
        img(C_10);
        check("id_valid_e3", o_valid, 1'b1);
        check("id_data", o_data, 13'h1005);
        img(C_10);
        check("id_b2b_1", o_valid, 1'b1);
        img(C_10);
        check("id_b2b_2", o_valid, 1'b1);
        check("id_data_b2b", o_data, 13'h1005);
        idle();
        idle();
        idle();
        check("id_drain_last", o_valid, 1'b1);
        idle();
        check("id_drained", o_valid, 1'b0);
        check("id_hold", o_data, 13'h1005);

        // Start-of-row restart in S_RUN
        col(1'b1, 1'b1, C_10);
        img(C_10);
        img(C_10);
        img(C_10);
        check("sof_col0", o_valid, 1'b0);
        img(C_10);
        check("sof_col1", o_valid, 1'b0);
        img(C_10);
        check("sof_col2", o_valid, 1'b1);
        check("sof_data", o_data, 13'h1005);

        // Kernel reload mid-run with -1 kernel, pixels 127: sum -1143 -> 13'h0FF7
        ker(K_NEG1);
        check("reload_kready", o_kernel_ready, 1'b0);
        check("reload_inflight0", o_valid, 1'b1);
        img(C_127);
        check("reload_inflight1", o_valid, 1'b1);
        img(C_127);
        check("reload_inflight2", o_valid, 1'b1);
        check("reload_inflight_data", o_data, 13'h1005);
        ker(K_NEG1);
        check("reload_quiet0", o_valid, 1'b0);
        check("reload_kready_mid", o_kernel_ready, 1'b0);
        ker(K_NEG1);
        check("reload_kready_done", o_kernel_ready, 1'b1);
        check("reload_ignored_img1", o_valid, 1'b0);
        img(C_127);
        check("reload_ignored_img2", o_valid, 1'b0);
        img(C_127);
        img(C_127);
        idle();
        idle();
        check("neg_valid_early", o_valid, 1'b0);
        idle();
        check("neg_valid", o_valid, 1'b1);
        check("neg_data", o_data, 13'h0FF7);
        check("neg_data2", o_data2, 13'h0FB8);
        idle();
        check("neg_pulse_end", o_valid, 1'b0);
        check("neg_hold", o_data, 13'h0FF7);

        // Large positive sum 145161: wrap or clamp in the OUT_SHIFT=4 instance
        ker(C_127);
        ker(C_127);
        ker(C_127);
        img(C_127);
        img(C_127);
        img(C_127);
        idle();
        idle();
        idle();
        check("big_valid", o_valid, 1'b1);
        check("big_data", o_data, 13'h146E);
        check("big_data_shift4", o_data2, SAT_EXP2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
